// File: rtl/pm_bus_arb.sv
// -----------------------------------------------------------------------------
// pm_bus_arb -- program-memory bus arbiter
//
// Shares one program-memory port between the sequencer instruction fetch and
// DAG data accesses. Grants are combinational from the current requests and
// the registered state. Data accesses win over fetches. A one-cycle return
// tracker steers the read data to the sequencer (ps_op) or to the DAG (dg_rdt).
//
// Optional feature: define PM_ARB_FAIR_EN to enable fetch fairness. After
// three consecutive data grants that blocked a pending fetch, the fetch gets
// the bus for one cycle. Without the macro, data has strict priority.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   fch_req, fch_add          instruction-fetch request and address
//   dt_req, dt_wrb, dt_add,   data-access request, direction (1 = write),
//   dt_wdt                    address and write value
//   pm_rd_dt                  memory read data, one cycle after a read select
//   pm_cslt, pm_wrb, pm_add,  memory chip select, write strobe, address,
//   pm_wdt                    write data
//   fch_gnt, dt_gnt           grant indications for this cycle
//   ps_stall                  fetch requested but not granted
//   ps_op, ps_op_vld          fetched instruction and its update strobe
//   dg_rdt, dg_rdt_vld        data read return and its update strobe
// -----------------------------------------------------------------------------
module pm_bus_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        fch_req,
  input  logic [15:0] fch_add,
  input  logic        dt_req,
  input  logic        dt_wrb,
  input  logic [15:0] dt_add,
  input  logic [31:0] dt_wdt,
  input  logic [31:0] pm_rd_dt,
  output logic        pm_cslt,
  output logic        pm_wrb,
  output logic [15:0] pm_add,
  output logic [31:0] pm_wdt,
  output logic        fch_gnt,
  output logic        dt_gnt,
  output logic        ps_stall,
  output logic [31:0] ps_op,
  output logic        ps_op_vld,
  output logic [31:0] dg_rdt,
  output logic        dg_rdt_vld
);

  // Type of the grant issued in the previous cycle; decides where the
  // memory read data goes at the next edge.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_FCH  = 2'd1,
    TAG_DRD  = 2'd2
  } tag_t;

  tag_t        tag_q, tag_d;
  logic [31:0] ps_op_q, ps_op_d;
  logic        ps_op_vld_q, ps_op_vld_d;
  logic [31:0] dg_rdt_q, dg_rdt_d;
  logic        dg_rdt_vld_q, dg_rdt_vld_d;
  logic        fch_gnt_c, dt_gnt_c;
  logic        fair_fch;

`ifdef PM_ARB_FAIR_EN
  logic [1:0] dt_run_q, dt_run_d;

  // Three data grants in a row have starved a waiting fetch.
  assign fair_fch = (dt_run_q == 2'd3);

  always_comb begin
    dt_run_d = 2'd0;
    if (dt_gnt_c && fch_req) begin
      dt_run_d = (dt_run_q == 2'd3) ? 2'd3 : dt_run_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dt_run_q <= 2'd0;
    end else begin
      dt_run_q <= dt_run_d;
    end
  end
`else
  assign fair_fch = 1'b0;
`endif

  // Grant selection. Everything is held off while reset is asserted so the
  // outputs are zero immediately.
  always_comb begin
    fch_gnt_c = 1'b0;
    dt_gnt_c  = 1'b0;
    if (rst) begin
      if (dt_req && !(fch_req && fair_fch)) begin
        dt_gnt_c = 1'b1;
      end else if (fch_req) begin
        fch_gnt_c = 1'b1;
      end
    end
  end

  // Memory port drive; all fields return to zero when idle.
  always_comb begin
    pm_cslt = 1'b0;
    pm_wrb  = 1'b0;
    pm_add  = 16'h0000;
    pm_wdt  = 32'h0000_0000;
    if (dt_gnt_c) begin
      pm_cslt = 1'b1;
      pm_wrb  = dt_wrb;
      pm_add  = dt_add;
      pm_wdt  = dt_wdt;
    end else if (fch_gnt_c) begin
      pm_cslt = 1'b1;
      pm_add  = fch_add;
    end
  end

  assign fch_gnt  = fch_gnt_c;
  assign dt_gnt   = dt_gnt_c;
  assign ps_stall = rst & fch_req & ~fch_gnt_c;

  // Return tracker: writes return nothing, so they record NONE.
  always_comb begin
    tag_d = TAG_NONE;
    if (fch_gnt_c) begin
      tag_d = TAG_FCH;
    end else if (dt_gnt_c && !dt_wrb) begin
      tag_d = TAG_DRD;
    end

    ps_op_d      = ps_op_q;
    ps_op_vld_d  = 1'b0;
    dg_rdt_d     = dg_rdt_q;
    dg_rdt_vld_d = 1'b0;
    if (tag_q == TAG_FCH) begin
      ps_op_d     = pm_rd_dt;
      ps_op_vld_d = 1'b1;
    end else if (tag_q == TAG_DRD) begin
      dg_rdt_d     = pm_rd_dt;
      dg_rdt_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q        <= TAG_NONE;
      ps_op_q      <= 32'h0000_0000;
      ps_op_vld_q  <= 1'b0;
      dg_rdt_q     <= 32'h0000_0000;
      dg_rdt_vld_q <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      ps_op_q      <= ps_op_d;
      ps_op_vld_q  <= ps_op_vld_d;
      dg_rdt_q     <= dg_rdt_d;
      dg_rdt_vld_q <= dg_rdt_vld_d;
    end
  end

  assign ps_op      = ps_op_q;
  assign ps_op_vld  = ps_op_vld_q;
  assign dg_rdt     = dg_rdt_q;
  assign dg_rdt_vld = dg_rdt_vld_q;

endmodule

// File: tb/tb_pm_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_pm_bus_arb -- directed self-checking bench for pm_bus_arb.
// Inputs change on the falling edge; combinational outputs are checked 1 ns
// after the change, registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pm_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        fch_req;
    logic [15:0] fch_add;
    logic        dt_req;
    logic        dt_wrb;
    logic [15:0] dt_add;
    logic [31:0] dt_wdt;
    logic [31:0] pm_rd_dt;
    logic        pm_cslt;
    logic        pm_wrb;
    logic [15:0] pm_add;
    logic [31:0] pm_wdt;
    logic        fch_gnt;
    logic        dt_gnt;
    logic        ps_stall;
    logic [31:0] ps_op;
    logic        ps_op_vld;
    logic [31:0] dg_rdt;
    logic        dg_rdt_vld;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    pm_bus_arb dut (
        .clk        (clk),
        .rst        (rst),
        .fch_req    (fch_req),
        .fch_add    (fch_add),
        .dt_req     (dt_req),
        .dt_wrb     (dt_wrb),
        .dt_add     (dt_add),
        .dt_wdt     (dt_wdt),
        .pm_rd_dt   (pm_rd_dt),
        .pm_cslt    (pm_cslt),
        .pm_wrb     (pm_wrb),
        .pm_add     (pm_add),
        .pm_wdt     (pm_wdt),
        .fch_gnt    (fch_gnt),
        .dt_gnt     (dt_gnt),
        .ps_stall   (ps_stall),
        .ps_op      (ps_op),
        .ps_op_vld  (ps_op_vld),
        .dg_rdt     (dg_rdt),
        .dg_rdt_vld (dg_rdt_vld)
    );

    initial begin : stim
        logic [7:0] exp_f;
`ifdef PM_ARB_FAIR_EN
        exp_f = 8'b1000_1000;
`else
        exp_f = 8'b0000_0000;
`endif
        rst      = 1'b1;
        fch_req  = 1'b0;
        fch_add  = 16'h0000;
        dt_req   = 1'b0;
        dt_wrb   = 1'b0;
        dt_add   = 16'h0000;
        dt_wdt   = 32'h0;
        pm_rd_dt = 32'h0;
        #3 rst = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        fch_req = 1'b1; fch_add = 16'h1234;
        #1;
        chk("rst_fch_gnt", fch_gnt, 1'b0);
        chk("rst_pm_cslt", pm_cslt, 1'b0);
        chk("rst_pm_add", pm_add, 16'h0000);
        chk("rst_ps_stall", ps_stall, 1'b0);
        chk("rst_ps_op", ps_op, 32'h0);
        chk("rst_vld", {ps_op_vld, dg_rdt_vld}, 2'b00);
        $display("reset state checked");

        fch_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fch_req = 1'b1; fch_add = 16'h0010;
        #1;
        chk("fch_gnt", fch_gnt, 1'b1);
        chk("fch_dt_gnt", dt_gnt, 1'b0);
        chk("fch_pm_cslt", pm_cslt, 1'b1);
        chk("fch_pm_wrb", pm_wrb, 1'b0);
        chk("fch_pm_add", pm_add, 16'h0010);
        chk("fch_ps_stall", ps_stall, 1'b0);
        @(negedge clk);
        fch_req = 1'b0; pm_rd_dt = 32'hA5A5A5A5;
        #1;
        chk("idle_pm_cslt", pm_cslt, 1'b0);
        chk("idle_pm_add", pm_add, 16'h0000);
        chk("fch_vld_early", ps_op_vld, 1'b0);
        @(posedge clk); #1;
        chk("fch_ps_op", ps_op, 32'hA5A5A5A5);
        chk("fch_ps_op_vld", ps_op_vld, 1'b1);
        chk("fch_dg_vld", dg_rdt_vld, 1'b0);
        $display("fetch read: addr 0010 -> ps_op %h", ps_op);

        @(negedge clk);
        fch_req = 1'b1; dt_req = 1'b1; dt_wrb = 1'b0; dt_add = 16'h0200;
        pm_rd_dt = 32'h0;
        #1;
        chk("both_dt_gnt", dt_gnt, 1'b1);
        chk("both_fch_gnt", fch_gnt, 1'b0);
        chk("both_ps_stall", ps_stall, 1'b1);
        chk("both_pm_add", pm_add, 16'h0200);
        chk("both_pm_wrb", pm_wrb, 1'b0);
        @(negedge clk);
        fch_req = 1'b0; dt_req = 1'b0; pm_rd_dt = 32'h5A5A0F0F;
        @(posedge clk); #1;
        chk("drd_dg_rdt", dg_rdt, 32'h5A5A0F0F);
        chk("drd_dg_vld", dg_rdt_vld, 1'b1);
        chk("drd_ps_op_hold", ps_op, 32'hA5A5A5A5);
        chk("drd_ps_op_vld", ps_op_vld, 1'b0);
        $display("data read: addr 0200 -> dg_rdt %h", dg_rdt);

        @(negedge clk);
        dt_req = 1'b1; dt_wrb = 1'b1; dt_add = 16'h0300; dt_wdt = 32'h12345678;
        pm_rd_dt = 32'hDEADBEEF;
        #1;
        chk("wr_dt_gnt", dt_gnt, 1'b1);
        chk("wr_pm_wrb", pm_wrb, 1'b1);
        chk("wr_pm_add", pm_add, 16'h0300);
        chk("wr_pm_wdt", pm_wdt, 32'h12345678);
        @(negedge clk);
        dt_req = 1'b0; dt_wrb = 1'b0; dt_wdt = 32'h0;
        #1;
        chk("wr_idle_pm_wdt", pm_wdt, 32'h0);
        @(posedge clk); #1;
        chk("wr_no_vld", {ps_op_vld, dg_rdt_vld}, 2'b00);
        chk("wr_dg_rdt_hold", dg_rdt, 32'h5A5A0F0F);
        $display("data write: addr 0300 data 12345678, no return");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fch_req = 1'b1; dt_req = 1'b1; dt_wrb = 1'b0; dt_add = 16'h0400;
            fch_add = 16'h0020;
            #1;
            chk("cont_fch_gnt", fch_gnt, exp_f[i]);
            chk("cont_dt_gnt", dt_gnt, !exp_f[i]);
            chk("cont_ps_stall", ps_stall, !exp_f[i]);
            $display("contention cycle %0d: fch_gnt %0b dt_gnt %0b", i, fch_gnt, dt_gnt);
        end
        @(negedge clk);
        fch_req = 1'b0; dt_req = 1'b0;
        repeat (2) @(posedge clk);

        @(negedge clk);
        fch_req = 1'b1; fch_add = 16'h0040; pm_rd_dt = 32'h11112222;
        #1;
        chk("rf_fch_gnt", fch_gnt, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; fch_req = 1'b0;
        #1;
        chk("rf_ps_op_rst", ps_op, 32'h0);
        chk("rf_vld_rst", ps_op_vld, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rf_vld_after", ps_op_vld, 1'b0);
        chk("rf_ps_op_after", ps_op, 32'h0);
        $display("reset after fetch grant: ps_op %h vld %0b", ps_op, ps_op_vld);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
